// File: rtl/led_source_arbiter_if.sv
// Bus between the CPU debug taps and the display arbiter: four requesters in,
// the selected owner and its registered display value out.
interface led_source_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] data3;
    logic        hold;
    logic [3:0]  grant;
    logic [1:0]  src;
    logic [31:0] Leddata;
    logic        busy;

    modport master (
        output req, data0, data1, data2, data3, hold,
        input  grant, src, Leddata, busy
    );

    modport slave (
        input  req, data0, data1, data2, data3, hold,
        output grant, src, Leddata, busy
    );
endinterface

// File: rtl/led_source_arbiter.sv
// Round-robin time-sharing of the 8-digit display between four 32-bit debug
// sources, with a minimum dwell per owner and a registered Leddata output.
module led_source_arbiter #(
    parameter int unsigned N_DWELL = 50_000_000
) (
    input logic                 clk,
    input logic                 rst,
    led_source_arbiter_if.slave bus
);
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_OWN  = 1'b1;
    localparam logic [31:0] CNT_LAST = 32'(N_DWELL - 1);

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    logic [0:0]  state, nxt_state;
    logic [1:0]  owner, nxt_owner;
    logic [1:0]  last, nxt_last;
    logic [31:0] cnt, nxt_cnt;
    logic [31:0] sel_data;
    pick_t       pick_all, pick_oth;

    // First set bit scanning upward from base+1 with wrap; base itself is last.
    function automatic pick_t rr_pick(input logic [3:0] r, input logic [1:0] base);
        pick_t      p;
        logic [1:0] idx;
        p = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!p.found && r[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    // In OWN, last always equals owner, so both scans start just past the owner.
    assign pick_all = rr_pick(bus.req, last);
    assign pick_oth = rr_pick(bus.req & ~(4'b0001 << owner), owner);

    always_comb begin
        nxt_state = state;
        nxt_owner = owner;
        nxt_last  = last;
        nxt_cnt   = cnt;
        case (state)
            ST_IDLE: begin
                if (pick_all.found) begin
                    nxt_state = ST_OWN;
                    nxt_owner = pick_all.idx;
                    nxt_last  = pick_all.idx;
                    nxt_cnt   = '0;
                end
            end
            default: begin
                if (!bus.req[owner]) begin
                    // Release beats hold and terminal count.
                    nxt_cnt = '0;
                    if (pick_all.found) begin
                        nxt_owner = pick_all.idx;
                        nxt_last  = pick_all.idx;
                    end else begin
                        nxt_state = ST_IDLE;
                        nxt_owner = '0;
                    end
                end else if (bus.hold) begin
                    nxt_cnt = cnt;
                end else if (cnt == CNT_LAST) begin
                    nxt_cnt = '0;
                    if (pick_oth.found) begin
                        nxt_owner = pick_oth.idx;
                        nxt_last  = pick_oth.idx;
                    end
                end else begin
                    nxt_cnt = cnt + 32'd1;
                end
            end
        endcase
    end

    always_comb begin
        sel_data = bus.data0;
        case (nxt_owner)
            2'd1:    sel_data = bus.data1;
            2'd2:    sel_data = bus.data2;
            2'd3:    sel_data = bus.data3;
            default: sel_data = bus.data0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            owner       <= '0;
            last        <= 2'd3;
            cnt         <= '0;
            bus.grant   <= '0;
            bus.src     <= '0;
            bus.busy    <= 1'b0;
            bus.Leddata <= '0;
        end else begin
            state     <= nxt_state;
            owner     <= nxt_owner;
            last      <= nxt_last;
            cnt       <= nxt_cnt;
            bus.busy  <= (nxt_state == ST_OWN);
            bus.grant <= (nxt_state == ST_OWN) ? (4'b0001 << nxt_owner) : 4'b0000;
            bus.src   <= (nxt_state == ST_OWN) ? nxt_owner : 2'd0;
            // Live value of the post-update owner; IDLE keeps the last shown value.
            if (nxt_state == ST_OWN)
                bus.Leddata <= sel_data;
        end
    end
endmodule
